// File: rtl/mips_alu_if.sv
// mips_alu_if: operand/control and result/flag bundle for the
// registered execute-stage ALU.
interface mips_alu_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] rega;
  logic [DATA_WIDTH-1:0] regb;
  logic [3:0]            control;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_alu;
  logic                  cout;
  logic                  equal;
  logic                  zero;
  logic                  overflow;

  modport master (
    output in_valid, rega, regb, control,
    input  out_valid, out_alu, cout, equal, zero, overflow
  );

  modport slave (
    input  in_valid, rega, regb, control,
    output out_valid, out_alu, cout, equal, zero, overflow
  );
endinterface

// File: rtl/mips_alu.sv
// mips_alu: registered 16-op integer ALU with carry/borrow,
// equality, zero and signed-overflow flags.
module mips_alu #(
  parameter int DATA_WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  mips_alu_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int SW = $clog2(DATA_WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLLV = 4'd5;
  localparam logic [3:0] OP_SRLV = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_NOR  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_SLL  = 4'd10;
  localparam logic [3:0] OP_COMP = 4'd11;
  localparam logic [3:0] OP_SRAV = 4'd12;
  localparam logic [3:0] OP_SUBU = 4'd13;
  localparam logic [3:0] OP_ADDU = 4'd14;
  localparam logic [3:0] OP_SRL  = 4'd15;

  logic [DW-1:0] w_a;
  logic [DW-1:0] w_b;
  logic [SW-1:0] w_shamt;
  logic          w_is_sub;
  logic [DW-1:0] w_b_op;
  logic [DW:0]   w_sum;
  logic          w_equal;
  logic          w_slt;
  logic          w_sltu;
  logic [DW-1:0] w_res;
  logic          w_cout;
  logic          w_ovf;

  logic          r_valid;
  logic [DW-1:0] r_alu;
  logic          r_cout;
  logic          r_equal;
  logic          r_zero;
  logic          r_ovf;

  assign w_a     = bus.rega;
  assign w_b     = bus.regb;
  assign w_shamt = w_b[SW-1:0];

  // Shared adder: subtraction is A + ~B + 1 on the same DW+1 bit sum.
  assign w_is_sub = (bus.control == OP_SUB) ||
                    (bus.control == OP_SUBU);
  assign w_b_op   = w_is_sub ? ~w_b : w_b;
  assign w_sum    = {1'b0, w_a} + {1'b0, w_b_op} +
                    {{DW{1'b0}}, w_is_sub};

  assign w_equal = (w_a == w_b);
  assign w_slt   = ($signed(w_a) < $signed(w_b));
  assign w_sltu  = (w_a < w_b);

  // Result and flag selection by opcode.
  always_comb begin
    w_res  = '0;
    w_cout = 1'b0;
    w_ovf  = 1'b0;
    unique case (bus.control)
      OP_ADD: begin
        w_res  = w_sum[DW-1:0];
        w_cout = w_sum[DW];
        w_ovf  = (w_a[DW-1] == w_b[DW-1]) &&
                 (w_sum[DW-1] != w_a[DW-1]);
      end
      OP_ADDU: begin
        w_res  = w_sum[DW-1:0];
        w_cout = w_sum[DW];
      end
      OP_SUB: begin
        w_res  = w_sum[DW-1:0];
        w_cout = ~w_sum[DW];
        w_ovf  = (w_a[DW-1] != w_b[DW-1]) &&
                 (w_sum[DW-1] != w_a[DW-1]);
      end
      OP_SUBU: begin
        w_res  = w_sum[DW-1:0];
        w_cout = ~w_sum[DW];
      end
      OP_AND:  w_res = w_a & w_b;
      OP_OR:   w_res = w_a | w_b;
      OP_XOR:  w_res = w_a ^ w_b;
      OP_NOR:  w_res = ~(w_a | w_b);
      OP_SLLV,
      OP_SLL:  w_res = w_a << w_shamt;
      OP_SRLV,
      OP_SRL:  w_res = w_a >> w_shamt;
      OP_SRAV: w_res = DW'($signed(w_a) >>> w_shamt);
      OP_SLT:  w_res = {{(DW-1){1'b0}}, w_slt};
      OP_SLTU: w_res = {{(DW-1){1'b0}}, w_sltu};
      OP_COMP: w_res = {{(DW-1){1'b0}}, w_equal};
      default: w_res = '0;
    endcase
  end

  // Result/flag registers: load on valid, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_alu   <= '0;
      r_cout  <= 1'b0;
      r_equal <= 1'b0;
      r_zero  <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_alu   <= w_res;
        r_cout  <= w_cout;
        r_equal <= w_equal;
        r_zero  <= (w_res == '0);
        r_ovf   <= w_ovf;
      end
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.out_alu   = r_alu;
  assign bus.cout      = r_cout;
  assign bus.equal     = r_equal;
  assign bus.zero      = r_zero;
  assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_mips_alu.sv
// tb_mips_alu: table-driven directed check of mips_alu plus
// reset, hold and back-to-back sequences.
module tb_mips_alu;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mips_alu_if #(.DATA_WIDTH(32)) bus ();

  mips_alu #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        cout;
    logic        eq;
    logic        zero;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Checks result, flags {cout,equal,zero,overflow} and valid.
  task automatic chk_out(input string name,
                         input logic [31:0] res,
                         input logic [3:0] flags,
                         input logic vld);
    chk({name, " out_alu"}, {32'h0, bus.out_alu}, {32'h0, res});
    chk({name, " flags"},
        {60'h0, bus.cout, bus.equal, bus.zero, bus.overflow},
        {60'h0, flags});
    chk({name, " out_valid"}, {63'h0, bus.out_valid},
        {63'h0, vld});
  endtask

  task automatic drive(input logic v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = v;
    bus.control  = op;
    bus.rega     = a;
    bus.regb     = b;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs.push_back('{"add_ovf",  4'd0,  32'h7FFFFFFF, 32'h1,
                     32'h80000000, 0, 0, 0, 1});
    vecs.push_back('{"add_carry",4'd0,  32'hFFFFFFFF, 32'h1,
                     32'h0, 1, 0, 1, 0});
    vecs.push_back('{"addu",     4'd14, 32'h7FFFFFFF, 32'h1,
                     32'h80000000, 0, 0, 0, 0});
    vecs.push_back('{"sub",      4'd1,  32'd50, 32'd20,
                     32'd30, 0, 0, 0, 0});
    vecs.push_back('{"sub_brw",  4'd1,  32'h0, 32'h1,
                     32'hFFFFFFFF, 1, 0, 0, 0});
    vecs.push_back('{"sub_ovf",  4'd1,  32'h80000000, 32'h1,
                     32'h7FFFFFFF, 0, 0, 0, 1});
    vecs.push_back('{"subu",     4'd13, 32'h80000000, 32'h1,
                     32'h7FFFFFFF, 0, 0, 0, 0});
    vecs.push_back('{"sub_zero", 4'd1,  32'd10, 32'd10,
                     32'h0, 0, 1, 1, 0});
    vecs.push_back('{"and",      4'd2,  32'h00FF, 32'h0F0F,
                     32'h000F, 0, 0, 0, 0});
    vecs.push_back('{"or",       4'd3,  32'h00FF, 32'h0F0F,
                     32'h0FFF, 0, 0, 0, 0});
    vecs.push_back('{"xor",      4'd4,  32'hAAAA5555, 32'hFFFF0000,
                     32'h55555555, 0, 0, 0, 0});
    vecs.push_back('{"nor",      4'd8,  32'hFF00FF00, 32'h00FF00FF,
                     32'h0, 0, 0, 1, 0});
    vecs.push_back('{"sllv_msk", 4'd5,  32'h1, 32'd33,
                     32'h2, 0, 0, 0, 0});
    vecs.push_back('{"srlv_msk", 4'd6,  32'h2, 32'd33,
                     32'h1, 0, 0, 0, 0});
    vecs.push_back('{"srav_neg", 4'd12, 32'h80000000, 32'h1,
                     32'hC0000000, 0, 0, 0, 0});
    vecs.push_back('{"srav_pos", 4'd12, 32'h40000000, 32'h2,
                     32'h10000000, 0, 0, 0, 0});
    vecs.push_back('{"sll",      4'd10, 32'h1, 32'h1,
                     32'h2, 0, 1, 0, 0});
    vecs.push_back('{"srl",      4'd15, 32'h2, 32'h1,
                     32'h1, 0, 0, 0, 0});
    vecs.push_back('{"slt",      4'd7,  32'hFFFFFFFF, 32'h1,
                     32'h1, 0, 0, 0, 0});
    vecs.push_back('{"sltu",     4'd9,  32'h1, 32'h2,
                     32'h1, 0, 0, 0, 0});
    vecs.push_back('{"sltu_big", 4'd9,  32'hFFFFFFFF, 32'h1,
                     32'h0, 0, 0, 1, 0});
    vecs.push_back('{"comp_eq",  4'd11, 32'd100, 32'd100,
                     32'h1, 0, 1, 0, 0});
    vecs.push_back('{"comp_ne",  4'd11, 32'd100, 32'd101,
                     32'h0, 0, 0, 1, 0});

    rst = 1'b1;
    drive(1'b0, 4'd0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 32'h0, 4'b0010, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      @(posedge clk);
      #1;
      chk_out(vecs[i].name, vecs[i].res,
              {vecs[i].cout, vecs[i].eq, vecs[i].zero, vecs[i].ovf},
              1'b1);
    end

    // Idle cycle: registers hold, valid drops.
    @(negedge clk);
    drive(1'b0, 4'd0, 32'h5, 32'h6);
    @(posedge clk);
    #1;
    chk_out("hold", 32'h0, 4'b0010, 1'b0);

    // Load a nonzero result, then reset with an op in flight.
    @(negedge clk);
    drive(1'b1, 4'd0, 32'd3, 32'd4);
    @(posedge clk);
    #1;
    chk_out("pre_rst", 32'd7, 4'b0000, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 4'd0, 32'd1, 32'd1);
    @(posedge clk);
    #1;
    chk_out("rst_inflight", 32'h0, 4'b0010, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 4'd0, 32'h0, 32'h0);

    // Back-to-back issue on consecutive edges.
    @(negedge clk);
    drive(1'b1, 4'd0, 32'd5, 32'd6);
    @(posedge clk);
    #1;
    chk_out("b2b_0", 32'd11, 4'b0000, 1'b1);
    drive(1'b1, 4'd1, 32'd6, 32'd6);
    @(posedge clk);
    #1;
    chk_out("b2b_1", 32'd0, 4'b0110, 1'b1);
    drive(1'b1, 4'd5, 32'h3, 32'd4);
    @(posedge clk);
    #1;
    chk_out("b2b_2", 32'h30, 4'b0000, 1'b1);
    drive(1'b0, 4'd0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    chk_out("b2b_idle", 32'h30, 4'b0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
